// File: rtl/ext_domain_power_sequencer.sv
// Power sequencer for one external power domain: walks switch, clock, reset and
// isolation controls through fixed power-up/power-down orders, waiting on the switch ack.
module ext_domain_power_sequencer #(
    parameter int ISO_DELAY   = 4,
    parameter int RST_DELAY   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pwr_on_req_i,
    input  logic       switch_ack_ni,
    input  logic       clr_timeout_i,
    output logic       switch_no,
    output logic       iso_no,
    output logic       rst_no,
    output logic       clkgate_en_no,
    output logic       on_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    localparam int MAX_DLY = (ISO_DELAY > RST_DELAY) ? ISO_DELAY : RST_DELAY;
    localparam int MAX_ALL = (MAX_DLY > ACK_TIMEOUT) ? MAX_DLY : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_DELAY - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_SW_ON      = 3'd1,
        S_CLK_ON     = 3'd2,
        S_RST_REL    = 3'd3,
        S_ON         = 3'd4,
        S_ISO_ON     = 3'd5,
        S_RST_ASSERT = 3'd6,
        S_SW_OFF     = 3'd7
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             tmo_set;
    logic             ack_sync_p0, ack_sync_p1;

    // Ack synchronizer: idles high so a fresh reset looks like "switch open".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_p0 <= 1'b1;
            ack_sync_p1 <= 1'b1;
        end else begin
            ack_sync_p0 <= switch_ack_ni;
            ack_sync_p1 <= ack_sync_p0;
        end
    end

    // One counter serves both roles: down-count in timed states, saturating up-count while waiting on ack.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tmo_set = 1'b0;
        case (state)
            S_OFF: begin
                if (pwr_on_req_i) begin
                    state_d = S_SW_ON;
                    cnt_d   = '0;
                end
            end
            S_SW_ON: begin
                if (!ack_sync_p1) begin
                    state_d = S_CLK_ON;
                    cnt_d   = RST_LOAD;
                end else begin
                    if (cnt != TMO_MAX) cnt_d = cnt + CNT_W'(1);
                    tmo_set = (cnt == TMO_LAST);
                end
            end
            S_CLK_ON: begin
                if (cnt == '0) begin
                    state_d = S_RST_REL;
                    cnt_d   = ISO_LOAD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_RST_REL: begin
                if (cnt == '0) state_d = S_ON;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            S_ON: begin
                if (!pwr_on_req_i) begin
                    state_d = S_ISO_ON;
                    cnt_d   = ISO_LOAD;
                end
            end
            S_ISO_ON: begin
                if (cnt == '0) begin
                    state_d = S_RST_ASSERT;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_RST_ASSERT: begin
                if (cnt == '0) begin
                    state_d = S_SW_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_SW_OFF: begin
                if (ack_sync_p1) begin
                    state_d = S_OFF;
                end else begin
                    if (cnt != TMO_MAX) cnt_d = cnt + CNT_W'(1);
                    tmo_set = (cnt == TMO_LAST);
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_OFF;
            cnt           <= '0;
            switch_no     <= 1'b1;
            iso_no        <= 1'b0;
            rst_no        <= 1'b0;
            clkgate_en_no <= 1'b0;
            on_o          <= 1'b0;
            busy_o        <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            switch_no     <= (state_d == S_OFF) || (state_d == S_SW_OFF);
            iso_no        <= (state_d == S_ON);
            rst_no        <= (state_d == S_RST_REL) || (state_d == S_ON) || (state_d == S_ISO_ON);
            clkgate_en_no <= (state_d == S_CLK_ON) || (state_d == S_RST_REL) ||
                             (state_d == S_ON) || (state_d == S_ISO_ON);
            on_o          <= (state_d == S_ON);
            busy_o        <= (state_d != S_OFF) && (state_d != S_ON);
            if (tmo_set)            timeout_o <= 1'b1;
            else if (clr_timeout_i) timeout_o <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ext_domain_power_sequencer.sv
// Bench for ext_domain_power_sequencer: two instances (default and minimum delays),
// a switch-ack latency model, a timestamp-based reference model and directed timing pins.
module tb_ext_domain_power_sequencer;

    localparam int TMO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic req   [2];
    logic clr   [2];
    logic ack_n [2] = '{1'b1, 1'b1};

    logic       sw_n [2], iso_n [2], rstd_n [2], cg_n [2], on [2], busy [2], tmo [2];
    logic [2:0] st   [2];
    logic [9:0] obs  [2];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  ack_mode [2];
    int          ack_lat  [2];
    logic [63:0] sw_hist  [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [3:0]  ack_hist [2];
    int          m_phase  [2];
    int          m_entry  [2];
    logic        m_tmo    [2];

    always #5 clk = ~clk;

    ext_domain_power_sequencer dut0 (
        .clk_i(clk), .rst_ni(rst_n), .pwr_on_req_i(req[0]), .switch_ack_ni(ack_n[0]),
        .clr_timeout_i(clr[0]), .switch_no(sw_n[0]), .iso_no(iso_n[0]), .rst_no(rstd_n[0]),
        .clkgate_en_no(cg_n[0]), .on_o(on[0]), .busy_o(busy[0]), .timeout_o(tmo[0]),
        .state_o(st[0])
    );

    ext_domain_power_sequencer #(.ISO_DELAY(1), .RST_DELAY(1), .ACK_TIMEOUT(TMO)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .pwr_on_req_i(req[1]), .switch_ack_ni(ack_n[1]),
        .clr_timeout_i(clr[1]), .switch_no(sw_n[1]), .iso_no(iso_n[1]), .rst_no(rstd_n[1]),
        .clkgate_en_no(cg_n[1]), .on_o(on[1]), .busy_o(busy[1]), .timeout_o(tmo[1]),
        .state_o(st[1])
    );

    assign obs[0] = {sw_n[0], iso_n[0], rstd_n[0], cg_n[0], on[0], busy[0], tmo[0], st[0]};
    assign obs[1] = {sw_n[1], iso_n[1], rstd_n[1], cg_n[1], on[1], busy[1], tmo[1], st[1]};

    function automatic int iso_d(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int rst_d(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Control values per state: {switch_no, iso_no, rst_no, clkgate_en_no, on_o}.
    function automatic logic [4:0] ctrl(input int p);
        case (p)
            1:       return 5'b00000;
            2:       return 5'b00010;
            3:       return 5'b00110;
            4:       return 5'b01111;
            5:       return 5'b00110;
            6:       return 5'b00000;
            default: return 5'b10000;
        endcase
    endfunction

    // The FSM at edge k acts on the ack value present at edge k-2.
    function automatic logic seen(input int i);
        return ack_hist[i][2'(cyc - 1)];
    endfunction

    function automatic int elapsed(input int i);
        return cyc + 1 - m_entry[i];
    endfunction

    function automatic logic times_out(input int i);
        return ((m_phase[i] == 1 && seen(i)) || (m_phase[i] == 7 && !seen(i))) &&
               (elapsed(i) == TMO);
    endfunction

    function automatic logic [9:0] expv(input int i);
        logic b;
        b = (m_phase[i] != 0) && (m_phase[i] != 4);
        return {ctrl(m_phase[i]), b, m_tmo[i], 3'(m_phase[i])};
    endfunction

    // Reference model: states advance by elapsed time since entry, ack by sampled history.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_phase[i]               <= 0;
                m_entry[i]               <= 0;
                m_tmo[i]                 <= 1'b0;
                ack_hist[i][2'(cyc + 1)] <= 1'b1;
            end else begin
                ack_hist[i][2'(cyc + 1)] <= ack_n[i];
                m_tmo[i] <= times_out(i) || (m_tmo[i] && !clr[i]);
                case (m_phase[i])
                    0: if (req[i])                   begin m_phase[i] <= 1; m_entry[i] <= cyc + 1; end
                    1: if (!seen(i))                 begin m_phase[i] <= 2; m_entry[i] <= cyc + 1; end
                    2: if (elapsed(i) == rst_d(i))   begin m_phase[i] <= 3; m_entry[i] <= cyc + 1; end
                    3: if (elapsed(i) == iso_d(i))   begin m_phase[i] <= 4; m_entry[i] <= cyc + 1; end
                    4: if (!req[i])                  begin m_phase[i] <= 5; m_entry[i] <= cyc + 1; end
                    5: if (elapsed(i) == iso_d(i))   begin m_phase[i] <= 6; m_entry[i] <= cyc + 1; end
                    6: if (elapsed(i) == rst_d(i))   begin m_phase[i] <= 7; m_entry[i] <= cyc + 1; end
                    7: if (seen(i))                  begin m_phase[i] <= 0; m_entry[i] <= cyc + 1; end
                    default: m_phase[i] <= 0;
                endcase
            end
        end
    end

    // Switch-ack model: ack follows switch_no after ack_lat cycles unless forced.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            sw_hist[i][6'(cyc)] <= sw_n[i];
            case (ack_mode[i])
                2'd1:    ack_n[i] <= 1'b1;
                2'd2:    ack_n[i] <= 1'b0;
                default: ack_n[i] <= (ack_lat[i] == 0) ? sw_n[i] : sw_hist[i][6'(cyc - ack_lat[i])];
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++)
                check($sformatf("model_inst%0d_cyc%0d", i, cyc), 32'(obs[i]), 32'(expv(i)));
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_state(input int i, input logic [2:0] s, input int lim, input string name);
        int k;
        k = 0;
        while (st[i] != s && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(st[i]), 32'(s));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, d0, on_cnt;
        req      = '{1'b0, 1'b0};
        clr      = '{1'b0, 1'b0};
        ack_mode = '{2'd0, 2'd0};
        ack_lat  = '{15, 0};

        repeat (4) @(negedge clk);
        check("reset_inst0", 32'(obs[0]), 32'h200);
        check("reset_inst1", 32'(obs[1]), 32'h200);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Default delays, A=15 power-up.
        req[0] = 1'b1;
        e0 = cyc + 1;
        wait_cyc(e0);
        check("up_sw_e0", 32'(sw_n[0]), 32'd0);
        check("up_busy_e0", 32'(busy[0]), 32'd1);
        wait_cyc(e0 + 21);
        check("up_rst_e21", 32'(rstd_n[0]), 32'd0);
        wait_cyc(e0 + 22);
        check("up_rst_e22", 32'(rstd_n[0]), 32'd1);
        wait_cyc(e0 + 25);
        check("up_on_e25", 32'(on[0]), 32'd0);
        check("up_busy_e25", 32'(busy[0]), 32'd1);
        wait_cyc(e0 + 26);
        check("up_on_e26", 32'(on[0]), 32'd1);
        check("up_busy_e26", 32'(busy[0]), 32'd0);
        repeat (5) @(negedge clk);

        // Power-down.
        req[0] = 1'b0;
        d0 = cyc + 1;
        wait_cyc(d0);
        check("dn_iso_d0", 32'(iso_n[0]), 32'd0);
        wait_cyc(d0 + 3);
        check("dn_rst_d3", 32'(rstd_n[0]), 32'd1);
        wait_cyc(d0 + 4);
        check("dn_rstcg_d4", 32'({rstd_n[0], cg_n[0]}), 32'd0);
        wait_cyc(d0 + 7);
        check("dn_sw_d7", 32'(sw_n[0]), 32'd0);
        wait_cyc(d0 + 8);
        check("dn_sw_d8", 32'(sw_n[0]), 32'd1);
        wait_cyc(d0 + 25);
        check("dn_state_d25", 32'(st[0]), 32'd7);
        wait_cyc(d0 + 26);
        check("dn_state_d26", 32'(st[0]), 32'd0);
        repeat (5) @(negedge clk);

        // Minimum delays, A=0.
        req[1] = 1'b1;
        e0 = cyc + 1;
        wait_cyc(e0);
        check("min_up_sw_e0", 32'(sw_n[1]), 32'd0);
        wait_cyc(e0 + 3);
        check("min_up_rst_e3", 32'(rstd_n[1]), 32'd0);
        wait_cyc(e0 + 4);
        check("min_up_on_e4", 32'({rstd_n[1], on[1]}), 32'b10);
        wait_cyc(e0 + 5);
        check("min_up_on_e5", 32'(on[1]), 32'd1);
        repeat (3) @(negedge clk);
        req[1] = 1'b0;
        d0 = cyc + 1;
        wait_cyc(d0);
        check("min_dn_iso_d0", 32'(iso_n[1]), 32'd0);
        wait_cyc(d0 + 1);
        check("min_dn_rst_d1", 32'({rstd_n[1], st[1]}), 32'd6);
        wait_cyc(d0 + 2);
        check("min_dn_sw_d2", 32'(sw_n[1]), 32'd1);
        wait_cyc(d0 + 4);
        check("min_dn_state_d4", 32'(st[1]), 32'd7);
        wait_cyc(d0 + 5);
        check("min_dn_state_d5", 32'(st[1]), 32'd0);
        repeat (5) @(negedge clk);

        // Power-up timeout with ack held high.
        ack_mode[0] = 2'd1;
        req[0] = 1'b1;
        e0 = cyc + 1;
        wait_cyc(e0 + 63);
        check("tmo_up_e63", 32'(tmo[0]), 32'd0);
        wait_cyc(e0 + 64);
        check("tmo_up_e64", 32'({tmo[0], st[0]}), 32'h9);
        wait_cyc(e0 + 70);
        check("tmo_up_wait", 32'(st[0]), 32'd1);
        ack_mode[0] = 2'd0;
        wait_state(0, 3'd4, 60, "tmo_up_reach_on");
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("tmo_clr", 32'(tmo[0]), 32'd0);

        // Power-down timeout with a clear pulse on the same edge.
        ack_mode[0] = 2'd2;
        req[0] = 1'b0;
        d0 = cyc + 1;
        wait_cyc(d0 + 71);
        check("tmo_dn_d71", 32'(tmo[0]), 32'd0);
        clr[0] = 1'b1;
        wait_cyc(d0 + 72);
        clr[0] = 1'b0;
        check("tmo_dn_setwins", 32'({tmo[0], st[0]}), 32'hF);
        ack_mode[0] = 2'd0;
        wait_state(0, 3'd0, 40, "tmo_dn_reach_off");
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("tmo_dn_clr", 32'(tmo[0]), 32'd0);

        // Request dropped during CLK_ON.
        req[0] = 1'b1;
        wait_state(0, 3'd2, 40, "toggle_clk_on");
        req[0] = 1'b0;
        on_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (on[0]) on_cnt++;
        end
        check("toggle_on_cycles", 32'(on_cnt), 32'd1);
        check("toggle_end_off", 32'(st[0]), 32'd0);

        // Asynchronous reset during RST_REL, then a fresh power-up.
        req[0] = 1'b1;
        wait_state(0, 3'd3, 40, "rst_reach_rst_rel");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_inst0", 32'(obs[0]), 32'h200);
        check("async_rst_inst1", 32'(obs[1]), 32'h200);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        wait_cyc(e0);
        check("rerun_sw_e0", 32'(sw_n[0]), 32'd0);
        wait_cyc(e0 + 21);
        check("rerun_rst_e21", 32'(rstd_n[0]), 32'd0);
        wait_cyc(e0 + 22);
        check("rerun_rst_e22", 32'(rstd_n[0]), 32'd1);
        wait_cyc(e0 + 25);
        check("rerun_on_e25", 32'(on[0]), 32'd0);
        wait_cyc(e0 + 26);
        check("rerun_on_e26", 32'(on[0]), 32'd1);

        // Random request toggling and clear pulses, checked cycle by cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    req[i] = !req[i];
                    if (i == 0) ack_lat[0] = $urandom_range(0, 15);
                end
                clr[i] = ($urandom_range(0, 63) == 0);
            end
        end
        req = '{1'b0, 1'b0};
        clr = '{1'b0, 1'b0};
        repeat (150) @(negedge clk);
        check("final_off_inst0", 32'({on[0], st[0]}), 32'd0);
        check("final_off_inst1", 32'({on[1], st[1]}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
